// File: rtl/div_cfg_arbiter_pkg.sv
// Shared types and constants for the divider-configuration arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_cfg_pkg;

  // Default divisor width; matches the divider DIN_n port.
  localparam int DW_DEFAULT = 32;

  // Divisor the divider powers up with; CUR_DIV/DIV_DIN must agree with it.
  localparam int DIV_RESET_VAL = 1;

  // Reprogramming sequence: pause the divider, load the new ratio, resume.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAUSE  = 2'd1,
    LOAD   = 2'd2,
    RESUME = 2'd3
  } state_e;

endpackage

// File: rtl/div_cfg_arbiter_if.sv
// Bundle between config requesters and the divider-config arbiter.
// Latency: n/a (wires only).
// Backpressure: REQ is level-held by a requester until it sees ACK or NACK.
// Ports: RUN_EN/REQ/REQ_DIV from requesters; ACK/NACK/BUSY/CUR_DIV back to
// them; DIV_DIN/DIV_CONFIG/DIV_ENABLE towards the divider.
interface div_cfg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 32
);
  logic                  RUN_EN;
  logic [N_REQ-1:0]      REQ;
  logic [N_REQ*DW-1:0]   REQ_DIV;
  logic [N_REQ-1:0]      ACK;
  logic [N_REQ-1:0]      NACK;
  logic                  BUSY;
  logic [DW-1:0]         CUR_DIV;
  logic [DW-1:0]         DIV_DIN;
  logic                  DIV_CONFIG;
  logic                  DIV_ENABLE;

  // Requester / agent side.
  modport master (
    output RUN_EN, REQ, REQ_DIV,
    input  ACK, NACK, BUSY, CUR_DIV, DIV_DIN, DIV_CONFIG, DIV_ENABLE
  );

  // Arbiter side.
  modport slave (
    input  RUN_EN, REQ, REQ_DIV,
    output ACK, NACK, BUSY, CUR_DIV, DIV_DIN, DIV_CONFIG, DIV_ENABLE
  );
endinterface

// File: rtl/div_cfg_arbiter_rr_arbiter.sv
// Round-robin priority search: first set request at or above ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to take the grant.
// Ports: req_i requests, ptr_i search start; gnt_o one-hot, gnt_idx_o index,
// vld_o any request present.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    gnt_idx_o,
  output logic             vld_o
);

  always_comb begin
    int          j;
    logic [IW-1:0] jx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    vld_o     = 1'b0;
    j         = 0;
    jx        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // Candidate index ptr+i, folded back into 0..N_REQ-1.
      j = int'(ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jx = IW'(j);
      if (!vld_o && req_i[jx]) begin
        vld_o      = 1'b1;
        gnt_idx_o  = jx;
        gnt_o[jx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_cfg_arbiter.sv
// Shares one frequency divider between N_REQ requesters; runs pause/load/resume.
// Latency: grant at e0 -> PAUSE, LOAD, RESUME(ACK) outputs after e0/e1/e2;
// zero divisor NACKs after e0. Next grant earliest at e4.
// Backpressure: REQ must stay high until ACK/NACK; BUSY marks a load in flight.
// Ports: CLK, RESET_N (sync, active-low), bus (slave side of the interface).
module div_cfg_arbiter
  import div_cfg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = DW_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET_N,
  div_cfg_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        win_idx_q, win_idx_d;
  logic [DW-1:0]        win_div_q, win_div_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [N_REQ-1:0]     nack_q, nack_d;
  logic                 busy_q, busy_d;
  logic [DW-1:0]        cur_div_q, cur_div_d;
  logic [DW-1:0]        din_q, din_d;
  logic                 cfg_q, cfg_d;
  logic                 en_q, en_d;

  logic [N_REQ-1:0]     arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;
  logic [DW-1:0]        sel_div;
  logic [N_REQ-1:0]     win_onehot;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .req_i     (bus.REQ),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .vld_o     (arb_vld)
  );

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Divisor offered by the current arbitration winner.
  always_comb begin
    sel_div = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IW'(i)) sel_div = bus.REQ_DIV[i*DW +: DW];
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx_q == IW'(i)) win_onehot[i] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_vld && (sel_div != '0)) state_d = PAUSE;
      PAUSE:   state_d = LOAD;
      LOAD:    state_d = RESUME;
      RESUME:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: every output is registered, so this computes the values
  // that will be visible while in state_d.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    win_idx_d = win_idx_q;
    win_div_d = win_div_q;
    ack_d     = '0;
    nack_d    = '0;
    busy_d    = busy_q;
    cur_div_d = cur_div_q;
    din_d     = din_q;
    cfg_d     = 1'b0;
    en_d      = en_q;
    case (state_q)
      IDLE: begin
        en_d   = bus.RUN_EN;
        busy_d = 1'b0;
        if (arb_vld) begin
          win_idx_d = arb_idx;
          win_div_d = sel_div;
          if (sel_div == '0) begin
            // Reject without touching the divider; move priority past it.
            nack_d   = arb_gnt;
            rr_ptr_d = ptr_inc(arb_idx);
          end else begin
            en_d   = 1'b0;
            busy_d = 1'b1;
          end
        end
      end
      PAUSE: begin
        en_d  = 1'b0;
        cfg_d = 1'b1;
        din_d = win_div_q;
      end
      LOAD: begin
        // RUN_EN is only looked at here for the resume cycle, so toggles
        // while paused/loading cannot disturb the sequence.
        en_d      = bus.RUN_EN;
        ack_d     = win_onehot;
        cur_div_d = win_div_q;
      end
      RESUME: begin
        en_d     = bus.RUN_EN;
        busy_d   = 1'b0;
        rr_ptr_d = ptr_inc(win_idx_q);
      end
      default: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rr_ptr_q  <= '0;
      win_idx_q <= '0;
      win_div_q <= '0;
      ack_q     <= '0;
      nack_q    <= '0;
      busy_q    <= 1'b0;
      cur_div_q <= DW'(DIV_RESET_VAL);
      din_q     <= DW'(DIV_RESET_VAL);
      cfg_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      win_idx_q <= win_idx_d;
      win_div_q <= win_div_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      busy_q    <= busy_d;
      cur_div_q <= cur_div_d;
      din_q     <= din_d;
      cfg_q     <= cfg_d;
      en_q      <= en_d;
    end
  end

  assign bus.ACK        = ack_q;
  assign bus.NACK       = nack_q;
  assign bus.BUSY       = busy_q;
  assign bus.CUR_DIV    = cur_div_q;
  assign bus.DIV_DIN    = din_q;
  assign bus.DIV_CONFIG = cfg_q;
  assign bus.DIV_ENABLE = en_q;

endmodule
